life_gen_ctrl: RTL and testbench
================================

# life_gen_ctrl

Generation controller sitting directly upstream of `life_array_4x4`. It loads seed patterns into the array through its `val`/`write_enb` port and paces generations by issuing single-cycle `step` pulses, in free-run, paused or single-step mode. It watches the array's `alive`/`alive_prev` outputs to count generations and to halt on extinction or a still life.

## Interface
- `PERIOD_W`, 8: width of `period`.
- `GEN_W`, 16: width of `gen_count`.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; high = free-run generations.
- `single`  in  1  one-cycle pulse; request one generation while not running.
- `load_req`  in  1  level; request to write `load_pat` into the array.
- `load_pat`  in  16  seed pattern, bit 4*row+col.
- `period`  in  PERIOD_W  idle cycles between generations in free-run; 0 treated as 1.
- `alive`  in  16  from array, current generation.
- `alive_prev`  in  16  from array, previous generation.
- `val`  out  16  to array, pattern to write.
- `write_enb`  out  1  to array, one-cycle write strobe.
- `step`  out  1  to array, one-cycle generation strobe.
- `load_ack`  out  1  one-cycle pulse; load performed.
- `gen_count`  out  GEN_W  generations since last load; wraps at 2^GEN_W.
- `stable`  out  1  sticky; still life detected.
- `extinct`  out  1  sticky; all cells dead.
- `osc`  out  1  sticky; period-2 oscillator detected (0 when feature compiled out).

Clock is `clk`. Reset is `reset`: one clock, synchronous, active-high.

## Operation
- States: IDLE, LOAD, WAIT, STEP, CHECK, HALT. Reset enters IDLE.
- IDLE: priority `load_req` > `single` > `run`. `load_req` → LOAD. `single` → STEP. `run` → WAIT, with the period counter cleared.
- LOAD: `val` = `load_pat` (captured on entry), `write_enb` = 1, `load_ack` = 1. Clears `gen_count`, `stable`, `extinct`, `osc`, and the history register. → IDLE.
- WAIT: counts cycles. After max(`period`,1) cycles → STEP. `load_req` → LOAD, taking priority. `run` low → IDLE. `period` is sampled every cycle.
- STEP: `step` = 1 for exactly one cycle; `gen_count` increments. → CHECK.
- CHECK: the array outputs now reflect the new generation.
  - `alive` == 0 → `extinct` = 1, go to HALT.
  - Else `alive` == `alive_prev` → `stable` = 1, go to HALT.
  - Else, if osc detection fires → `osc` = 1, go to HALT.
  - Else → WAIT if `run` is high, otherwise IDLE.
- HALT: `step` = 0. Leaves only on `load_req` (→ LOAD) or reset. `single` and `run` are ignored.
- `single` asserted in any state other than IDLE is dropped.
- `val` holds its last loaded value outside LOAD.

## Timing
- Reset values: `step` 0, `write_enb` 0, `load_ack` 0, `val` 0x0000, `gen_count` 0, `stable` 0, `extinct` 0, `osc` 0.
- All outputs are registered.
- `write_enb` and `load_ack` are high in the same single cycle. The array shows the pattern on `alive` the following cycle.
- `step` is never high on two consecutive cycles. The minimum gap is 2 low cycles (CHECK plus at least 1 WAIT cycle), which satisfies the array's edge-sensitive step.
- Free-run step-to-step interval = max(`period`,1) + 2 cycles.
- IDLE→STEP on `single`: `step` goes high 1 cycle after the `single` pulse is sampled.
- `run` dropping during STEP or CHECK lets the in-flight generation complete; the FSM then returns to IDLE.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values. The array contents are not touched.

## Configuration
- `LIFE_OSC_DETECT_EN` defined: a 16-bit history register captures `alive_prev` on every CHECK. From the 2nd generation after a load, `alive` == history sets `osc` and halts. Stable and extinct checks take precedence.
- Undefined: no history register, `osc` tied 0, and period-2 patterns run indefinitely.

## Test plan
Bench instantiates `life_gen_ctrl` driving a real `life_array_4x4`, with edge inputs tied 0.
- Reset held 1 cycle → all outputs at reset values; state IDLE; no `step` pulses while `run` = 0.
- Load 0x0660 (block), `run` = 1, `period` = 3 → `write_enb` and `load_ack` pulse once; one `step`; then `stable` = 1, `gen_count` = 1, halted, no further steps.
- Load 0x0001, `single` pulse → `step` 1 cycle later; `alive` = 0x0000; `extinct` = 1, `gen_count` = 1.
- Load 0x0070 (blinker), `run` = 1, `period` = 3 → steps exactly 5 cycles apart.
  - With `LIFE_OSC_DETECT_EN`: `alive` 0x0222 then 0x0070; `osc` = 1, `gen_count` = 2, halt.
  - Without it: still stepping with `gen_count` = 10 and `osc` = 0.
- Free-run blinker, assert `load_req` with 0x0660 during WAIT → LOAD next cycle; `gen_count` = 0, flags cleared, `alive` = 0x0660.
- Free-run blinker, `reset` pulsed mid-WAIT → `step` stays 0 afterwards, `gen_count` = 0; `alive` keeps its last generation.

Source files
------------

// File: rtl/life_gen_ctrl.sv
// Generation controller for life_array_4x4: seeds the array, paces step pulses, halts on extinction/still life.
// Optional period-2 oscillator detection is compiled in with `define LIFE_OSC_DETECT_EN.
module life_gen_ctrl #(
    parameter int PERIOD_W = 8,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                single,
    input  logic                load_req,
    input  logic [15:0]         load_pat,
    input  logic [PERIOD_W-1:0] period,
    input  logic [15:0]         alive,
    input  logic [15:0]         alive_prev,
    output logic [15:0]         val,
    output logic                write_enb,
    output logic                step,
    output logic                load_ack,
    output logic [GEN_W-1:0]    gen_count,
    output logic                stable,
    output logic                extinct,
    output logic                osc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        STEP  = 3'd3,
        CHECK = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t              state_reg;
    logic [PERIOD_W-1:0] cnt_reg;
    logic [15:0]         val_reg;
    logic                write_enb_reg;
    logic                step_reg;
    logic                load_ack_reg;
    logic [GEN_W-1:0]    gen_count_reg;
    logic                stable_reg;
    logic                extinct_reg;
    logic                osc_reg;
    logic                wait_done;
    logic                osc_hit;

    // A period of 0 behaves like 1; >= keeps a mid-wait period decrease from overshooting.
    assign wait_done = (period == '0) || (cnt_reg >= (period - PERIOD_W'(1)));

`ifdef LIFE_OSC_DETECT_EN
    logic [15:0] hist_reg;
    logic        hist_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_reg       <= 16'h0000;
            hist_valid_reg <= 1'b0;
        end else if (state_reg == LOAD) begin
            hist_reg       <= 16'h0000;
            hist_valid_reg <= 1'b0;
        end else if (state_reg == CHECK) begin
            hist_reg       <= alive_prev;
            hist_valid_reg <= 1'b1;
        end
    end

    // hist_reg holds the generation two back only once a first CHECK has occurred.
    assign osc_hit = hist_valid_reg && (alive == hist_reg);
`else
    assign osc_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            val_reg       <= 16'h0000;
            write_enb_reg <= 1'b0;
            step_reg      <= 1'b0;
            load_ack_reg  <= 1'b0;
            gen_count_reg <= '0;
            stable_reg    <= 1'b0;
            extinct_reg   <= 1'b0;
            osc_reg       <= 1'b0;
        end else begin
            write_enb_reg <= 1'b0;
            step_reg      <= 1'b0;
            load_ack_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_req) begin
                        state_reg     <= LOAD;
                        val_reg       <= load_pat;
                        write_enb_reg <= 1'b1;
                        load_ack_reg  <= 1'b1;
                        gen_count_reg <= '0;
                        stable_reg    <= 1'b0;
                        extinct_reg   <= 1'b0;
                        osc_reg       <= 1'b0;
                    end else if (single) begin
                        state_reg     <= STEP;
                        step_reg      <= 1'b1;
                        gen_count_reg <= gen_count_reg + GEN_W'(1);
                    end else if (run) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                    end
                end
                LOAD: state_reg <= IDLE;
                WAIT: begin
                    if (load_req) begin
                        state_reg     <= LOAD;
                        val_reg       <= load_pat;
                        write_enb_reg <= 1'b1;
                        load_ack_reg  <= 1'b1;
                        gen_count_reg <= '0;
                        stable_reg    <= 1'b0;
                        extinct_reg   <= 1'b0;
                        osc_reg       <= 1'b0;
                    end else if (!run) begin
                        state_reg <= IDLE;
                    end else if (wait_done) begin
                        state_reg     <= STEP;
                        step_reg      <= 1'b1;
                        gen_count_reg <= gen_count_reg + GEN_W'(1);
                    end else begin
                        cnt_reg <= cnt_reg + PERIOD_W'(1);
                    end
                end
                STEP: state_reg <= CHECK;
                CHECK: begin
                    if (alive == 16'h0000) begin
                        extinct_reg <= 1'b1;
                        state_reg   <= HALT;
                    end else if (alive == alive_prev) begin
                        stable_reg <= 1'b1;
                        state_reg  <= HALT;
                    end else if (osc_hit) begin
                        osc_reg   <= 1'b1;
                        state_reg <= HALT;
                    end else if (run) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    if (load_req) begin
                        state_reg     <= LOAD;
                        val_reg       <= load_pat;
                        write_enb_reg <= 1'b1;
                        load_ack_reg  <= 1'b1;
                        gen_count_reg <= '0;
                        stable_reg    <= 1'b0;
                        extinct_reg   <= 1'b0;
                        osc_reg       <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign val       = val_reg;
    assign write_enb = write_enb_reg;
    assign step      = step_reg;
    assign load_ack  = load_ack_reg;
    assign gen_count = gen_count_reg;
    assign stable    = stable_reg;
    assign extinct   = extinct_reg;
    assign osc       = osc_reg;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl driving a behavioural 4x4 life array with dead edges.
module tb_life_gen_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        single = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] load_pat = 16'h0000;
    logic [7:0]  period = 8'd3;
    logic [15:0] alive;
    logic [15:0] alive_prev;
    logic [15:0] val;
    logic        write_enb;
    logic        step;
    logic        load_ack;
    logic [15:0] gen_count;
    logic        stable;
    logic        extinct;
    logic        osc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    life_gen_ctrl #(.PERIOD_W(8), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .single(single),
        .load_req(load_req), .load_pat(load_pat), .period(period),
        .alive(alive), .alive_prev(alive_prev), .val(val),
        .write_enb(write_enb), .step(step), .load_ack(load_ack),
        .gen_count(gen_count), .stable(stable), .extinct(extinct), .osc(osc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] life_next(input logic [15:0] a);
        logic [15:0] n;
        int nb;
        int rr;
        int cc;
        n = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                nb = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
                            nb += int'(a[4*rr+cc]);
                    end
                end
                n[4*r+c] = a[4*r+c] ? (nb == 2 || nb == 3) : (nb == 3);
            end
        end
        return n;
    endfunction

    // Array model: not reset by the controller's reset.
    initial begin
        alive = 16'h0000;
        alive_prev = 16'h0000;
    end
    always @(posedge clk) begin
        if (write_enb) begin
            alive_prev <= alive;
            alive      <= val;
        end else if (step) begin
            alive_prev <= alive;
            alive      <= life_next(alive);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds load_req until the write strobe appears, so it works from any state.
    task automatic do_load(input logic [15:0] pat);
        bit seen = 0;
        load_pat = pat;
        load_req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (write_enb) seen = 1;
        end
        load_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL load_timeout: write_enb got 0 required 1 (pat %h)", pat);
        end
        $display("load pat=%h at cycle %0d", pat, cyc);
    endtask

    task automatic wait_step(output bit seen);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (step) seen = 1;
        end
    endtask

    task automatic test_reset();
        int steps = 0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({step, write_enb, load_ack} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b required 000", {step, write_enb, load_ack});
        end
        checks++;
        if (val !== 16'h0000 || gen_count !== 16'h0000) begin
            errors++; $display("FAIL reset_val_gen: val %h gen %0d required 0000 0", val, gen_count);
        end
        checks++;
        if ({stable, extinct, osc} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {stable, extinct, osc});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) steps++;
        end
        checks++;
        if (steps != 0) begin
            errors++; $display("FAIL idle_no_step: steps %0d required 0", steps);
        end
        $display("reset done, steps while idle=%0d", steps);
    endtask

    task automatic test_block_stable();
        int we_n = 0, ack_n = 0, steps = 0;
        period = 8'd3;
        run = 1'b1;
        load_pat = 16'h0660;
        load_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            load_req = 1'b0;
            if (write_enb) we_n++;
            if (load_ack) ack_n++;
            if (step) steps++;
        end
        checks++;
        if (we_n != 1 || ack_n != 1) begin
            errors++; $display("FAIL block_load_pulses: we %0d ack %0d required 1 1", we_n, ack_n);
        end
        checks++;
        if (steps != 1) begin
            errors++; $display("FAIL block_steps: got %0d required 1", steps);
        end
        checks++;
        if (stable !== 1'b1 || extinct !== 1'b0 || gen_count !== 16'd1) begin
            errors++; $display("FAIL block_stable: stable %b extinct %b gen %0d required 1 0 1", stable, extinct, gen_count);
        end
        run = 1'b0;
        $display("block: steps=%0d gen=%0d stable=%b", steps, gen_count, stable);
    endtask

    task automatic test_single_extinct();
        do_load(16'h0001);
        tick();
        checks++;
        if (alive !== 16'h0001) begin
            errors++; $display("FAIL single_seed: alive %h required 0001", alive);
        end
        single = 1'b1;
        tick();
        single = 1'b0;
        checks++;
        if (step !== 1'b1) begin
            errors++; $display("FAIL single_latency: step %b required 1", step);
        end
        tick();
        checks++;
        if (alive !== 16'h0000 || step !== 1'b0) begin
            errors++; $display("FAIL single_gen: alive %h step %b required 0000 0", alive, step);
        end
        tick();
        checks++;
        if (extinct !== 1'b1 || stable !== 1'b0 || gen_count !== 16'd1) begin
            errors++; $display("FAIL extinct_flag: extinct %b stable %b gen %0d required 1 0 1", extinct, stable, gen_count);
        end
        $display("single: extinct=%b gen=%0d", extinct, gen_count);
    endtask

    task automatic test_blinker();
        int last_step = -1, bad_gap = 0, steps = 0;
        logic [15:0] seq[$];
        bit prev_step = 0;
        bit done = 0;
        period = 8'd3;
        do_load(16'h0070);
        run = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (prev_step) seq.push_back(alive);
            prev_step = step;
            if (step) begin
                if (last_step >= 0 && cyc - last_step != 5) bad_gap++;
                last_step = cyc;
                steps++;
            end
`ifdef LIFE_OSC_DETECT_EN
            if (osc && i > 60) done = 1;
`else
            if (gen_count == 16'd10) done = 1;
`endif
        end
        checks++;
        if (seq.size() < 2 || seq[0] !== 16'h0222 || seq[1] !== 16'h0070) begin
            errors++; $display("FAIL blinker_seq: got %0d gens, first %h required 0222 then 0070", seq.size(), (seq.size() > 0) ? seq[0] : 16'hxxxx);
        end
        checks++;
        if (bad_gap != 0 || steps < 2) begin
            errors++; $display("FAIL blinker_gap: bad gaps %0d steps %0d required 0 gaps of 5", bad_gap, steps);
        end
`ifdef LIFE_OSC_DETECT_EN
        checks++;
        if (osc !== 1'b1 || gen_count !== 16'd2 || steps != 2) begin
            errors++; $display("FAIL blinker_osc: osc %b gen %0d steps %0d required 1 2 2", osc, gen_count, steps);
        end
`else
        checks++;
        if (!done || osc !== 1'b0 || stable !== 1'b0) begin
            errors++; $display("FAIL blinker_run: reached %b osc %b stable %b required 1 0 0", done, osc, stable);
        end
`endif
        run = 1'b0;
        $display("blinker: steps=%0d gen=%0d osc=%b", steps, gen_count, osc);
    endtask

    task automatic test_load_during_wait();
        bit seen;
        period = 8'd3;
        do_load(16'h0070);
        run = 1'b1;
        wait_step(seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL lw_step_timeout: step got 0 required 1");
        end
        tick();
        tick();
        load_pat = 16'h0660;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        run = 1'b0;
        checks++;
        if (write_enb !== 1'b1 || load_ack !== 1'b1) begin
            errors++; $display("FAIL lw_load: we %b ack %b required 1 1", write_enb, load_ack);
        end
        checks++;
        if (gen_count !== 16'd0 || {stable, extinct, osc} !== 3'b000) begin
            errors++; $display("FAIL lw_clear: gen %0d flags %b required 0 000", gen_count, {stable, extinct, osc});
        end
        tick();
        checks++;
        if (alive !== 16'h0660 || val !== 16'h0660) begin
            errors++; $display("FAIL lw_alive: alive %h val %h required 0660 0660", alive, val);
        end
        $display("load during wait: alive=%h gen=%0d", alive, gen_count);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        int steps = 0;
        logic [15:0] saved;
        period = 8'd3;
        do_load(16'h0070);
        run = 1'b1;
        wait_step(seen);
        tick();
        tick();
        saved = alive;
        reset = 1'b1;
        run = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (!seen || saved !== 16'h0222) begin
            errors++; $display("FAIL rm_pre: step seen %b alive %h required 1 0222", seen, saved);
        end
        checks++;
        if (step !== 1'b0 || gen_count !== 16'd0 || val !== 16'h0000) begin
            errors++; $display("FAIL rm_outputs: step %b gen %0d val %h required 0 0 0000", step, gen_count, val);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) steps++;
        end
        checks++;
        if (steps != 0 || alive !== 16'h0222) begin
            errors++; $display("FAIL rm_after: steps %0d alive %h required 0 0222", steps, alive);
        end
        $display("reset mid-run: steps after=%0d alive=%h", steps, alive);
    endtask

    initial begin
        test_reset();
        test_block_stable();
        test_single_extinct();
        test_blinker();
        test_load_during_wait();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
